// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor, LSB first (optional ovf output: SERIAL_SUB_OVF_EN)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_nx;
    logic             res_bit;
    logic             last;

    // Full-subtractor slice on the current LSB pair; result enters the accumulator MSB
    always_comb begin
        res_bit         = sa[0] ^ sb[0] ^ br;
        br_nx           = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        acc_nx          = acc >> 1;
        acc_nx[WIDTH-1] = res_bit;
        last            = (cnt == LAST_BIT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs; start only matters in IDLE
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, serial datapath, and result publish on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            acc  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                sa  <= a;
                sb  <= b;
                br  <= bin;
                cnt <= '0;
            end else if (state == SHIFT) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_nx;
                acc <= acc_nx;
                if (!last) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    // Results stay frozen here until the next operation finishes
                    diff <= acc_nx;
                    bout <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB stage differs from borrow out of it
                    ovf  <= br ^ br_nx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_dones = 0;
    int busy_cnt = 0;
    int done_cyc[$];
    logic [WIDTH+1:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a done pulse
    always @(negedge clk) begin
        logic [WIDTH+1:0] e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                chk("busy_cycles", busy_cnt, WIDTH);
                busy_cnt = 0;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff", int'(diff), int'(e[WIDTH-1:0]));
                    chk("bout", int'(bout), int'(e[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
                    chk("ovf", int'(ovf), int'(e[WIDTH+1]));
`endif
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibin,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        sb_q.push_back({eo, eb, ed});
        exp_dones++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        rst_n = 1'b1;

        // Directed vectors: a, b, bin -> diff, bout, ovf
        issue(8'd5,   8'd3,   1'b0, 8'h02, 1'b0, 1'b0); wait_done();
        issue(8'd3,   8'd5,   1'b0, 8'hFE, 1'b1, 1'b0); wait_done();
        issue(8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, 1'b0); wait_done();
        issue(8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0, 1'b0); wait_done();
        issue(8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1); wait_done();
        issue(8'h7F,  8'hFF,  1'b0, 8'h80, 1'b1, 1'b1); wait_done();

        // Hold check: result persists after done
        repeat (3) @(negedge clk);
        chk("hold_diff", int'(diff), 8'h80);
        chk("hold_bout", int'(bout), 1);

        // Start re-pulsed at edge 3 with new operands is ignored
        issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'h55; b = 8'h11; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("ignore_single_done", done_cnt, exp_dones);

        // Reset at edge 4 aborts; outputs clear immediately; no done follows
        issue(8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0);
        void'(sb_q.pop_back());
        exp_dones--;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt, exp_dones);
        issue(8'h40, 8'h11, 1'b1, 8'h2E, 1'b0, 1'b0); wait_done();

        // Back-to-back with start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
        sb_q.push_back({1'b0, 1'b0, 8'h05});
        exp_dones++;
        begin
            int n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("b2b_timeout", 0, 1);
        end
        a = 8'd1; b = 8'd2; bin = 1'b0;
        sb_q.push_back({1'b0, 1'b1, 8'hFF});
        exp_dones++;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        if (done_cyc.size() >= 2)
            chk("b2b_period", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], WIDTH + 2);
        else
            chk("b2b_done_count", done_cyc.size(), 2);

        repeat (4) @(negedge clk);
        chk("total_dones", done_cnt, exp_dones);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
